// File: rtl/rm_monitor_ctrl.sv
// rm_monitor_ctrl
// Front end for a runtime-verification monitor. It arbitrates two
// valid/ready symbol streams into one monitor input and keeps sticky
// violation status. The monitor is held in reset for two cycles after
// reset or clear. Optionally it stops symbol issue on a violation.
//
// Optional feature macro: RM_CTRL_VCNT_EN
//   When defined, a 16-bit saturating count of violation cycles is kept
//   and exported on viol_count.
//   When undefined, that port and its counter do not exist.

module rm_monitor_ctrl #(
  parameter int SYM_W   = 8,
  parameter int NUM_LTL = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               halt_on_viol,
  input  logic               a_valid,
  input  logic [SYM_W-1:0]   a_symbols,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [SYM_W-1:0]   b_symbols,
  output logic               b_ready,
  output logic               mon_run,
  output logic [SYM_W-1:0]   mon_symbols,
  output logic               mon_reset,
  input  logic [NUM_LTL-1:0] mon_flags,
  output logic [NUM_LTL-1:0] viol_sticky,
  output logic               halted
`ifdef RM_CTRL_VCNT_EN
  ,
  output logic [15:0]        viol_count
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // Round-robin pointer encoding: which requester wins on contention.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  state_t             state_r;
  logic               init_cnt_r;     // 0 = first INIT cycle, 1 = second
  logic               ptr_r;
  logic               mon_reset_r;
  logic               halted_r;
  logic [NUM_LTL-1:0] sticky_r;
  logic               mon_run_r;
  logic [SYM_W-1:0]   mon_symbols_r;

  logic               grant_a_s;
  logic               grant_b_s;
  logic               viol_any_s;
  logic               can_grant_s;

  assign viol_any_s  = |mon_flags;
  // clear wins over any same-cycle grant.
  assign can_grant_s = (state_r == ST_ACTIVE) && enable && !clear;

  // Combinational arbitration: one winner per cycle, round-robin on contention.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (can_grant_s) begin
      if (a_valid && b_valid) begin
        if (ptr_r == PTR_A) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (a_valid) begin
        grant_a_s = 1'b1;
      end else if (b_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Control FSM: INIT countdown, sticky flag accumulation, halt and pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= 1'b0;
      ptr_r       <= PTR_A;
      mon_reset_r <= 1'b1;
      halted_r    <= 1'b0;
      sticky_r    <= {NUM_LTL{1'b0}};
    end else if (clear) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= 1'b0;
      ptr_r       <= PTR_A;
      mon_reset_r <= 1'b1;
      halted_r    <= 1'b0;
      sticky_r    <= {NUM_LTL{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          // Two full cycles with the monitor held in reset.
          if (init_cnt_r == 1'b1) begin
            state_r     <= ST_ACTIVE;
            init_cnt_r  <= 1'b0;
            mon_reset_r <= 1'b0;
          end else begin
            init_cnt_r  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          sticky_r <= sticky_r | mon_flags;
          if (grant_a_s) begin
            ptr_r <= PTR_B;
          end else if (grant_b_s) begin
            ptr_r <= PTR_A;
          end else begin
            ptr_r <= ptr_r;
          end
          // A grant taken this cycle still issues; only later ones stop.
          if (viol_any_s && halt_on_viol) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_ACTIVE;
          end
        end
        ST_HALT: begin
          // Only clear leaves HALT; status is frozen here.
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= 1'b0;
          mon_reset_r <= 1'b1;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  // Issue register: the granted symbol goes to the monitor one cycle after the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon_run_r     <= 1'b0;
      mon_symbols_r <= {SYM_W{1'b0}};
    end else if (grant_a_s) begin
      mon_run_r     <= 1'b1;
      mon_symbols_r <= a_symbols;
    end else if (grant_b_s) begin
      mon_run_r     <= 1'b1;
      mon_symbols_r <= b_symbols;
    end else begin
      mon_run_r     <= 1'b0;
      mon_symbols_r <= mon_symbols_r;
    end
  end

  assign mon_run     = mon_run_r;
  assign mon_symbols = mon_symbols_r;
  assign mon_reset   = mon_reset_r;
  assign halted      = halted_r;
  assign viol_sticky = sticky_r;

`ifdef RM_CTRL_VCNT_EN
  logic [15:0] vcnt_r;

  // Saturating count of ACTIVE cycles that carry any violation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt_r <= 16'h0000;
    end else if (clear) begin
      vcnt_r <= 16'h0000;
    end else if ((state_r == ST_ACTIVE) && viol_any_s && (vcnt_r != 16'hFFFF)) begin
      vcnt_r <= vcnt_r + 16'h0001;
    end else begin
      vcnt_r <= vcnt_r;
    end
  end

  assign viol_count = vcnt_r;
`endif

endmodule

// File: tb/tb_rm_monitor_ctrl.sv
// Self-checking bench for rm_monitor_ctrl: directed scenarios followed by
// randomized traffic. A behavioural model predicts grants and status. The
// expected issued symbols go into a scoreboard queue that a monitor
// drains whenever mon_run is seen.
module tb_rm_monitor_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       halt_on_viol;
  logic       a_valid;
  logic [7:0] a_symbols;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_symbols;
  logic       b_ready;
  logic       mon_run;
  logic [7:0] mon_symbols;
  logic       mon_reset;
  logic [3:0] mon_flags;
  logic [3:0] viol_sticky;
  logic       halted;
`ifdef RM_CTRL_VCNT_EN
  logic [15:0] viol_count;
`endif

  rm_monitor_ctrl #(.SYM_W(8), .NUM_LTL(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .halt_on_viol (halt_on_viol),
    .a_valid      (a_valid),
    .a_symbols    (a_symbols),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_symbols    (b_symbols),
    .b_ready      (b_ready),
    .mon_run      (mon_run),
    .mon_symbols  (mon_symbols),
    .mon_reset    (mon_reset),
    .mon_flags    (mon_flags),
    .viol_sticky  (viol_sticky),
    .halted       (halted)
`ifdef RM_CTRL_VCNT_EN
    ,
    .viol_count   (viol_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [7:0] sym;
  } item_t;
  item_t exp_q[$];
  logic [7:0] last_sym = 8'h00;

  // Reference model state
  int       m_init_left;
  bit       m_halted;
  bit       m_turn_b;
  bit [3:0] m_sticky;
  int       m_vcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_init_left = 2;
    m_halted    = 1'b0;
    m_turn_b    = 1'b0;
    m_sticky    = 4'b0000;
    m_vcount    = 0;
  endtask

  // Registered outputs after an edge compared to the model.
  task automatic check_regs();
    chk("mon_reset",   {31'd0, mon_reset}, {31'd0, (m_init_left > 0)});
    chk("halted",      {31'd0, halted},    {31'd0, m_halted});
    chk("viol_sticky", {28'd0, viol_sticky}, {28'd0, m_sticky});
`ifdef RM_CTRL_VCNT_EN
    chk("viol_count",  {16'd0, viol_count}, m_vcount);
`endif
  endtask

  // Apply one cycle of inputs, predict/check grants, then advance the model across the next edge.
  task automatic drive_and_step(input bit en, input bit clr, input bit hov,
                                input bit av, input logic [7:0] as,
                                input bit bv, input logic [7:0] bs,
                                input logic [3:0] fl);
    bit active, ga, gb;
    enable = en; clear = clr; halt_on_viol = hov;
    a_valid = av; a_symbols = as; b_valid = bv; b_symbols = bs; mon_flags = fl;
    #1;
    active = !clr && en && (m_init_left == 0) && !m_halted;
    ga = 1'b0; gb = 1'b0;
    if (active) begin
      if (av && bv) begin
        if (m_turn_b) gb = 1'b1; else ga = 1'b1;
      end else if (av) ga = 1'b1;
      else if (bv) gb = 1'b1;
    end
    chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
    if (ga) exp_q.push_back('{due: cyc + 1, sym: as});
    if (gb) exp_q.push_back('{due: cyc + 1, sym: bs});
    if (clr) begin
      model_reset();
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_halted) begin
      m_sticky = m_sticky | fl;
      if (fl != 4'b0000 && m_vcount < 65535) m_vcount++;
      if (fl != 4'b0000 && hov) m_halted = 1'b1;
      if (ga) m_turn_b = 1'b1;
      else if (gb) m_turn_b = 1'b0;
    end
  endtask

  task automatic cycle(input bit en, input bit clr, input bit hov,
                       input bit av, input logic [7:0] as,
                       input bit bv, input logic [7:0] bs,
                       input logic [3:0] fl);
    @(posedge clk);
    #1;
    check_regs();
    drive_and_step(en, clr, hov, av, as, bv, bs, fl);
  endtask

  // Asynchronous reset in mid-stream; pending issues are discarded.
  task automatic do_reset(input int hold, input bit av, input logic [7:0] as);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    last_sym = 8'h00;
    #1;
    chk("rst_mon_run",     {31'd0, mon_run},   32'd0);
    chk("rst_mon_symbols", {24'd0, mon_symbols}, 32'd0);
    chk("rst_mon_reset",   {31'd0, mon_reset}, 32'd1);
    chk("rst_halted",      {31'd0, halted},    32'd0);
    chk("rst_sticky",      {28'd0, viol_sticky}, 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    reset = 1'b1;
    drive_and_step(1'b1, 1'b0, 1'b0, av, as, 1'b0, 8'h00, 4'b0000);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a symbol.
  task automatic monitor_loop();
    item_t it;
    forever begin
      @(negedge clk);
      if (mon_run === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_run", 32'd1, 32'd0);
        end else begin
          it = exp_q.pop_front();
          chk("issue_sym",   {24'd0, mon_symbols}, {24'd0, it.sym});
          chk("issue_cycle", cyc, it.due);
          last_sym = it.sym;
        end
      end else begin
        chk("hold_sym", {24'd0, mon_symbols}, {24'd0, last_sym});
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missed_issue", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    bit         hov_r;
    bit         en_r, clr_r, av_r, bv_r;
    logic [7:0] as_r, bs_r;
    logic [3:0] fl_r;

    reset = 1'b1;
    enable = 1'b0; clear = 1'b0; halt_on_viol = 1'b0;
    a_valid = 1'b0; a_symbols = 8'h00; b_valid = 1'b0; b_symbols = 8'h00;
    mon_flags = 4'b0000;
    model_reset();
    #2;
    reset = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset values while held.
    repeat (2) @(posedge clk);
    #1;
    chk("por_mon_run",     {31'd0, mon_run},   32'd0);
    chk("por_mon_symbols", {24'd0, mon_symbols}, 32'd0);
    chk("por_mon_reset",   {31'd0, mon_reset}, 32'd1);
    chk("por_halted",      {31'd0, halted},    32'd0);
    chk("por_sticky",      {28'd0, viol_sticky}, 32'd0);
`ifdef RM_CTRL_VCNT_EN
    chk("por_viol_count",  {16'd0, viol_count}, 32'd0);
`endif

    // Release with A requesting: grants start in cycle 2, issue in cycle 3.
    reset = 1'b1;
    drive_and_step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 4'b0000);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 4'b0000);

    // Clear, then contention: expect 11,22,11,22.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 4'b0000);

    // Violation with halt enabled while granting.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 4'b0100);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 1'b1, 8'h35, 4'b0000);
    chk("halt_sticky", {28'd0, viol_sticky}, 32'h4);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h36, 1'b1, 8'h37, 4'b0010);

    // Clear from HALT with all flags set: flags ignored.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 4'b1111);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 4'b0000);
    chk("clear_sticky", {28'd0, viol_sticky}, 32'd0);
    chk("clear_mon_reset", {31'd0, mon_reset}, 32'd1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 4'b0000);

    // Accumulation without halt.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h50, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h51, 1'b1, 8'h52, 4'b1000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000);
    chk("accum_sticky", {28'd0, viol_sticky}, 32'h9);
    chk("accum_halted", {31'd0, halted}, 32'd0);
`ifdef RM_CTRL_VCNT_EN
    chk("accum_viol_count", {16'd0, viol_count}, 32'd4);
`endif

    // Reset mid-stream with a grant pending.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 1'b1, 8'h61, 4'b0000);
    do_reset(1, 1'b1, 8'h62);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h63, 1'b0, 8'h00, 4'b0000);

    // Randomized traffic.
    hov_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) hov_r = ~hov_r;
      en_r  = ($urandom_range(0, 9) != 0);
      clr_r = ($urandom_range(0, 39) == 0);
      av_r  = $urandom_range(0, 1);
      bv_r  = $urandom_range(0, 1);
      as_r  = 8'($urandom);
      bs_r  = 8'($urandom);
      fl_r  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cycle(en_r, clr_r, hov_r, av_r, as_r, bv_r, bs_r, fl_r);
    end

    // Drain and confirm nothing is left outstanding.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_monitor_ctrl.md
RM_MONITOR_CTRL -- requirements
Module: rm_monitor_ctrl

Interface
REQ-001 Parameter: SYM_W, 8, symbol width presented to the monitor.
REQ-002 Parameter: NUM_LTL, 4, number of LTL violation flags returned by the monitor.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: enable  input  1  level; low suppresses all grants.
REQ-006 Port: clear  input  1  single-cycle pulse; clears status and re-initialises the monitor.
REQ-007 Port: halt_on_viol  input  1  level; high makes any violation stop symbol issue.
REQ-008 Port: a_valid / a_symbols / a_ready  in / in / out  1 / SYM_W / 1  requester A valid-ready stream.
REQ-009 Port: b_valid / b_symbols / b_ready  in / in / out  1 / SYM_W / 1  requester B valid-ready stream.
REQ-010 Port: mon_run  output  1  run strobe to the monitor, one per issued symbol.
REQ-011 Port: mon_symbols  output  SYM_W  symbol to the monitor, valid when mon_run=1.
REQ-012 Port: mon_reset  output  1  active-high monitor reset.
REQ-013 Port: mon_flags  input  NUM_LTL  monitor violation flags.
REQ-014 Port: viol_sticky  output  NUM_LTL  per-flag sticky OR of mon_flags.
REQ-015 Port: halted  output  1  high while in HALT.
REQ-016 Port: viol_count  output  16  violation-cycle count; present only with RM_CTRL_VCNT_EN.

Function
REQ-017 FSM states INIT, ACTIVE, HALT; INIT holds exactly 2 cycles with mon_reset=1, then goes to ACTIVE.
REQ-018 In INIT and HALT, a_ready=b_ready=0 and no grants occur.
REQ-019 In ACTIVE with enable=1, at most one grant per cycle; a_ready/b_ready are combinational grants, asserted only to the winner.
REQ-020 Arbitration: single valid requester wins; both valid → round-robin pointer decides, and the pointer flips to the other requester after each grant.
REQ-021 Latency: a grant in cycle N drives mon_run=1 and mon_symbols=granted symbols in cycle N+1; without a grant, mon_run=0 and mon_symbols holds its value.
REQ-022 In ACTIVE, every cycle viol_sticky <= viol_sticky | mon_flags.
REQ-023 In ACTIVE, |mon_flags=1 and halt_on_viol=1 → HALT next cycle; a grant in the same cycle still completes and issues in the first HALT cycle.
REQ-024 HALT exits only via clear, to INIT; flags are not accumulated in INIT or HALT.
REQ-025 clear in any state: viol_sticky=0, viol_count=0, pointer=A, go to INIT next cycle; clear has priority over same-cycle flags and grants (ready forced 0).
REQ-026 enable=0 in ACTIVE: no grants, mon_run=0 next cycle, flag accumulation continues.

Reset
REQ-027 reset low, asynchronously: state=INIT with a 2-cycle count restarted, mon_run=0, mon_symbols=0, mon_reset=1, viol_sticky=0, halted=0, viol_count=0, pointer=A.
REQ-028 After reset deasserts, INIT runs its full 2 cycles before the first grant.

Configuration
REQ-029 Macro RM_CTRL_VCNT_EN defined: viol_count increments by 1 each ACTIVE cycle with |mon_flags=1 and saturates at 16'hFFFF.
REQ-030 RM_CTRL_VCNT_EN undefined: port viol_count and its counter are absent; all other behaviour is identical.

Verification
REQ-031 Release reset, a_valid=1 → mon_reset=1 for cycles 0-1, a_ready=1 first in cycle 2, mon_run=1 with a_symbols in cycle 3.
REQ-032 a_valid=b_valid=1 for 4 cycles with symbols 8'h11 / 8'h22 → mon_symbols sequence 11,22,11,22 on consecutive cycles.
REQ-033 halt_on_viol=1, mon_flags=4'b0100 for one cycle while granting → viol_sticky=4'b0100, granted symbol issued, halted=1 next cycle, readys 0 thereafter.
REQ-034 In HALT, pulse clear with mon_flags=4'b1111 → viol_sticky=0, mon_reset=1 for 2 cycles, then grants resume.
REQ-035 halt_on_viol=0, mon_flags=4'b0001 for 3 cycles then 4'b1000 for 1 cycle → viol_sticky=4'b1001, no halt, viol_count=4 with RM_CTRL_VCNT_EN.
REQ-036 Assert reset mid-stream with a grant pending → mon_run=0 immediately, no symbol issued after reset release until INIT completes.
